// File: rtl/lfsr_digit_gen.sv
// lfsr_digit_gen: Galois-LFSR random word source.
// It supports seeding, STEPS LFSR advances per output word, a per-nibble
// digit map (raw, decimal fold, decimal modulo, octal) and a valid/ready
// output handshake.
module lfsr_digit_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] POLY         = 32'h000000AF,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h00000001,
  parameter int               STEPS        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int         NIBBLES = WIDTH / 4;
  localparam logic [7:0] STEPS_C = 8'(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] seed_val;
  logic [WIDTH-1:0] mapped_d;
  logic [WIDTH-1:0] out_data_q;
  logic [7:0]       step_cnt_q;
  logic             out_valid_q;

  // One Galois step: shift left and fold the taps back in when the MSB falls out.
  assign lfsr_d   = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
  // A zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_val = (seed == '0) ? DEFAULT_SEED : seed;

  // Digit map for one nibble. Fold mirrors A..F onto 5..0 and modulo wraps
  // A..F onto 0..5.
  function automatic logic [3:0] map_nibble(input logic [3:0] n, input logic [1:0] m);
    logic [3:0] r;
    r = n;
    case (m)
      2'b00:   r = n;
      2'b01:   r = (n < 4'd10) ? n : ~n;
      2'b10:   r = (n < 4'd10) ? n : n - 4'd10;
      default: r = {1'b0, n[2:0]};
    endcase
    return r;
  endfunction

  // The word captured on an advance is the mapped form of the new LFSR value.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_map
    assign mapped_d[gi*4 +: 4] = map_nibble(lfsr_d[gi*4 +: 4], mode);
  end

  // Control FSM: seed handling, step counting, word capture and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= '0;
      step_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (seed_load) begin
      // A reload discards any pending word and restarts the sequence.
      lfsr_q      <= seed_val;
      step_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            lfsr_q     <= seed_val;
            step_cnt_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            if (lfsr_q == '0) begin
              // Recover from a locked-up LFSR without counting a step.
              lfsr_q <= DEFAULT_SEED;
            end else begin
              lfsr_q <= lfsr_d;
              if (step_cnt_q + 8'd1 == STEPS_C) begin
                out_data_q  <= mapped_d;
                out_valid_q <= 1'b1;
                step_cnt_q  <= '0;
                state_q     <= HOLD;
              end else begin
                step_cnt_q <= step_cnt_q + 8'd1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (enable) begin
              lfsr_q <= lfsr_d;
              if (STEPS == 1) begin
                // Back-to-back words: the consumed word is replaced at once.
                out_data_q <= mapped_d;
              end else begin
                // This advance already counts as the first step of the next word.
                step_cnt_q  <= 8'd1;
                out_valid_q <= 1'b0;
                state_q     <= RUN;
              end
            end else begin
              out_valid_q <= 1'b0;
              step_cnt_q  <= '0;
              state_q     <= RUN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_digit_gen.sv
// Directed bench for lfsr_digit_gen.
// One instance runs with STEPS=1 and a second with STEPS=4.
module tb_lfsr_digit_gen;

  logic        clk;
  logic        rst_n;

  logic        enable, seed_load, out_ready;
  logic [31:0] seed;
  logic [1:0]  mode;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;

  logic        enable4, seed_load4, out_ready4;
  logic [31:0] seed4;
  logic [1:0]  mode4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic        busy4;

  int compared   = 0;
  int mismatched = 0;

  lfsr_digit_gen #(.WIDTH(32), .POLY(32'h000000AF), .DEFAULT_SEED(32'h1), .STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load), .seed(seed),
    .mode(mode), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  lfsr_digit_gen #(.WIDTH(32), .POLY(32'h000000AF), .DEFAULT_SEED(32'h1), .STEPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .seed_load(seed_load4), .seed(seed4),
    .mode(mode4), .out_ready(out_ready4), .out_valid(out_valid4), .out_data(out_data4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("check %-16s observed %h expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mode_exp [4];
    mode_exp[0] = 32'h000000AF;
    mode_exp[1] = 32'h00000050;
    mode_exp[2] = 32'h00000005;
    mode_exp[3] = 32'h00000027;

    rst_n = 1'b0;
    enable = 1'b0; seed_load = 1'b0; out_ready = 1'b0; seed = '0; mode = 2'b00;
    enable4 = 1'b0; seed_load4 = 1'b0; out_ready4 = 1'b0; seed4 = '0; mode4 = 2'b00;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Raw word from seed 0x80000000, held with out_ready low.
    seed = 32'h80000000; mode = 2'b00; enable = 1'b1;
    tick();
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("raw_valid", {31'd0, out_valid}, 32'd1);
    check("raw_data", out_data, 32'h000000AF);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, 32'h000000AF);
    end

    // Same seed with each digit map; each reload also discards the held word.
    for (int m = 0; m < 4; m++) begin
      seed_load = 1'b1; seed = 32'h80000000; mode = 2'(m);
      tick();
      check("reload_valid", {31'd0, out_valid}, 32'd0);
      seed_load = 1'b0;
      tick();
      check("map_valid", {31'd0, out_valid}, 32'd1);
      check("map_data", out_data, mode_exp[m]);
    end
    // Changing mode while holding must not alter the held word.
    mode = 2'b00;
    tick();
    check("mode_chg_data", out_data, 32'h00000027);

    // Zero seed substitutes DEFAULT_SEED; one word per cycle with out_ready high.
    seed_load = 1'b1; seed = 32'h0;
    tick();
    seed_load = 1'b0; out_ready = 1'b1;
    tick();
    check("zs_word0", out_data, 32'h00000002);
    check("zs_valid0", {31'd0, out_valid}, 32'd1);
    tick();
    check("zs_word1", out_data, 32'h00000004);
    check("zs_valid1", {31'd0, out_valid}, 32'd1);
    tick();
    check("zs_word2", out_data, 32'h00000008);

    // seed_load while a word is pending: valid drops, stale data is not re-captured.
    out_ready = 1'b0; seed_load = 1'b1; seed = 32'h80000000;
    tick();
    check("sl_valid", {31'd0, out_valid}, 32'd0);
    check("sl_data", out_data, 32'h00000008);
    seed_load = 1'b0;
    tick();
    check("sl_new_word", out_data, 32'h000000AF);
    check("sl_new_valid", {31'd0, out_valid}, 32'd1);

    // Handshake with enable low: valid drops and the LFSR stays frozen.
    enable = 1'b0; out_ready = 1'b1;
    tick();
    check("hs_en0_valid", {31'd0, out_valid}, 32'd0);
    check("hs_en0_busy", {31'd0, busy}, 32'd1);
    tick();
    check("run_en0_valid", {31'd0, out_valid}, 32'd0);
    enable = 1'b1; out_ready = 1'b0;
    tick();
    check("resume_valid", {31'd0, out_valid}, 32'd1);
    check("resume_data", out_data, 32'h0000015E);

    // STEPS=4 instance: one word every fourth cycle.
    seed4 = 32'h1; mode4 = 2'b00; out_ready4 = 1'b1; enable4 = 1'b1;
    tick();
    check("s4_load_valid", {31'd0, out_valid4}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("s4_valid", {31'd0, out_valid4}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i % 4 == 0) check("s4_data", out_data4, 32'h1 << i);
    end

    // Asynchronous reset in the middle of RUN.
    out_ready = 1'b0; seed_load = 1'b1; seed = 32'h1;
    tick();
    seed_load = 1'b0;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("post_rst_word", out_data, 32'h00000002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
